cache_drain_ctrl: RTL

Sequencer behind the drain instruction (opcode `0x7f`) in the MEM stage. It waits for the store buffer to empty, then walks every data-cache line. Each valid, dirty line is written back to main memory over the 128-bit line write port and its dirty bit is cleared. The pipeline is held stalled while the drain runs, and completion is signalled with a one-cycle pulse.

---
 rtl/cache_drain_ctrl_if.sv | 36 +++
 rtl/cache_drain_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/cache_drain_ctrl_if.sv
// Cache-side and memory-side bus of the drain sequencer.
//   Cache read/maintenance port: line_idx, line_valid, line_dirty, line_tag, line_data,
//                                clean_en, inv_en
//   Memory line-write port:      mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_ack
// master: the drain controller; slave: cache arrays plus main memory.
interface cache_drain_ctrl_if #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 128
);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 4;

    logic [IDX_W-1:0]  line_idx;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              clean_en;
    logic              inv_en;

    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_wr_ack;

    modport master (
        output line_idx, clean_en, inv_en, mem_wr_req, mem_wr_addr, mem_wr_data,
        input  line_valid, line_dirty, line_tag, line_data, mem_wr_ack
    );

    modport slave (
        input  line_idx, clean_en, inv_en, mem_wr_req, mem_wr_addr, mem_wr_data,
        output line_valid, line_dirty, line_tag, line_data, mem_wr_ack
    );
endinterface

// File: rtl/cache_drain_ctrl.sv
// Drain sequencer: waits for the store buffer to empty, then walks every cache line and
// writes each valid+dirty line back to memory, clearing its dirty bit. Holds the pipeline
// stalled while running and pulses drain_done at the end.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   drain_req, sb_empty drain instruction present / store buffer empty
//   bus                 cache read + memory line-write port (cache_drain_ctrl_if.master)
//   drain_busy          pipeline stall, high in every state except idle
//   drain_done          one-cycle completion pulse
//   wb_count            lines written back by the most recent drain
// Optional feature: define CACHE_DRAIN_INVALIDATE_EN to also invalidate every line.
module cache_drain_ctrl #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 128
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        drain_req,
    input  logic                        sb_empty,
    cache_drain_ctrl_if.master          bus,
    output logic                        drain_busy,
    output logic                        drain_done,
    output logic [$clog2(NUM_LINES):0]  wb_count
);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitSb, StRead, StCheck, StWrite, StClean, StDone
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic              req_q;
    logic              clean_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            clean_q    <= 1'b0;
            drain_done <= 1'b0;
            wb_count   <= '0;
        end else begin
            clean_q    <= 1'b0;
            drain_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (drain_req) begin
                        state_q  <= StWaitSb;
                        idx_q    <= '0;
                        wb_count <= '0;
                    end
                end
                StWaitSb: begin
                    if (sb_empty) state_q <= StRead;
                end
                StRead: state_q <= StCheck;
                StCheck: begin
                    if (bus.line_valid && bus.line_dirty) begin
                        addr_q  <= {bus.line_tag, idx_q, 4'b0000};
                        data_q  <= bus.line_data;
                        req_q   <= 1'b1;
                        state_q <= StWrite;
                    end else if (idx_q == LastIdx) begin
                        state_q    <= StDone;
                        drain_done <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StRead;
                    end
                end
                StWrite: begin
                    if (bus.mem_wr_ack) begin
                        req_q    <= 1'b0;
                        clean_q  <= 1'b1;
                        wb_count <= wb_count + 1'b1;
                        state_q  <= StClean;
                    end
                end
                StClean: begin
                    if (idx_q == LastIdx) begin
                        state_q    <= StDone;
                        drain_done <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StRead;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign drain_busy      = (state_q != StIdle);
    assign bus.line_idx    = idx_q;
    assign bus.mem_wr_req  = req_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = data_q;
    assign bus.clean_en    = clean_q;

`ifdef CACHE_DRAIN_INVALIDATE_EN
    // Dirty lines are invalidated in CLEAN; valid clean lines during CHECK, since they
    // never reach CLEAN.
    assign bus.inv_en = clean_q ||
                        ((state_q == StCheck) && bus.line_valid && !bus.line_dirty);
`else
    assign bus.inv_en = 1'b0;
`endif

endmodule
